// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM with memory-ready handshake
module multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic [1:0] PCsrc,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       Jal,
   output logic       slt,
   output logic       MemToReg,
   output logic       ALUsrcA,
   output logic [1:0] ALUsrcB,
   output logic [1:0] ALUop,
   output logic [3:0] state,
   output logic       done,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_R_EX     = 4'd2,
      S_R_WB     = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_LW_WB    = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BEQ      = 4'd8,
      S_JUMP     = 4'd9,
      S_JAL      = 4'd10,
      S_JR       = 4'd11,
      S_I_EX     = 4'd12,
      S_I_WB     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_JR  = 6'b001000;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   state_t cur, nxt;
   logic   ready;
   logic   r_alu;

   // Masking with rst keeps the reset-time outputs free of enables even if memory reports ready.
   assign ready = mem_ready & rst;
   assign r_alu = (func == F_ADD) || (func == F_SUB) || (func == F_AND) ||
                  (func == F_OR)  || (func == F_SLT);
   assign state = cur;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cur <= S_FETCH;
      else
         cur <= nxt;
   end

   always_comb begin
      nxt      = S_FETCH;
      pc_en    = 1'b0;
      PCsrc    = 2'd0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      Jal      = 1'b0;
      slt      = 1'b0;
      MemToReg = 1'b0;
      ALUsrcA  = 1'b0;
      ALUsrcB  = 2'd0;
      ALUop    = 2'd0;
      done     = 1'b0;
      illegal  = 1'b0;

      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUsrcB = 2'd1;
            IRWrite = ready;
            pc_en   = ready;
            nxt     = ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUsrcB = 2'd3;
            case (opcode)
               OP_RTYPE: begin
                  if (r_alu)             nxt = S_R_EX;
                  else if (func == F_JR) nxt = S_JR;
                  else                   illegal = 1'b1;
               end
               OP_LW, OP_SW:     nxt = S_MEM_ADDR;
               OP_BEQ:           nxt = S_BEQ;
               OP_J:             nxt = S_JUMP;
               OP_JAL:           nxt = S_JAL;
               OP_ADDI, OP_SLTI: nxt = S_I_EX;
               default:          illegal = 1'b1;
            endcase
         end
         S_R_EX: begin
            ALUsrcA = 1'b1;
            ALUop   = 2'd2;
            nxt     = S_R_WB;
         end
         S_R_WB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            done     = 1'b1;
            slt      = (func == F_SLT);
         end
         S_MEM_ADDR: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'd2;
            nxt     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            nxt     = ready ? S_LW_WB : S_MEM_RD;
         end
         S_LW_WB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
            done     = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            done     = ready;
            nxt      = ready ? S_FETCH : S_MEM_WR;
         end
         S_BEQ: begin
            ALUsrcA = 1'b1;
            ALUop   = 2'd1;
            PCsrc   = 2'd1;
            pc_en   = zero;
            done    = 1'b1;
         end
         S_JUMP: begin
            PCsrc = 2'd2;
            pc_en = 1'b1;
            done  = 1'b1;
         end
         S_JAL: begin
            PCsrc    = 2'd2;
            pc_en    = 1'b1;
            Jal      = 1'b1;
            RegWrite = 1'b1;
            done     = 1'b1;
         end
         S_JR: begin
            PCsrc = 2'd3;
            pc_en = 1'b1;
            done  = 1'b1;
         end
         S_I_EX: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'd2;
            ALUop   = (opcode == OP_SLTI) ? 2'd1 : 2'd0;
            nxt     = S_I_WB;
         end
         S_I_WB: begin
            RegWrite = 1'b1;
            done     = 1'b1;
            slt      = (opcode == OP_SLTI);
         end
         default: nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] func;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic [1:0] PCsrc;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       Jal;
   logic       slt;
   logic       MemToReg;
   logic       ALUsrcA;
   logic [1:0] ALUsrcB;
   logic [1:0] ALUop;
   logic [3:0] state;
   logic       done;
   logic       illegal;

   int tests = 0;
   int fails = 0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] F_JR     = 6'b001000;
   localparam logic [5:0] F_ADD    = 6'b100000;
   localparam logic [5:0] F_SLT    = 6'b101010;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .PCsrc(PCsrc), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .Jal(Jal), .slt(slt),
      .MemToReg(MemToReg), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
      .ALUop(ALUop), .state(state), .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Order: pc_en PCsrc IorD MemRead MemWrite IRWrite RegWrite RegDst Jal slt MemToReg ALUsrcA ALUsrcB ALUop done illegal
   logic [18:0] outs;
   assign outs = {pc_en, PCsrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                  Jal, slt, MemToReg, ALUsrcA, ALUsrcB, ALUop, done, illegal};

   function automatic logic [18:0] ev(input int pe, ps, io, mr, mw, ir, rw, rd,
                                      jl, sl, mt, sa, sb, op, dn, il);
      return {pe[0], ps[1:0], io[0], mr[0], mw[0], ir[0], rw[0], rd[0],
              jl[0], sl[0], mt[0], sa[0], sb[1:0], op[1:0], dn[0], il[0]};
   endfunction

   task automatic test_reset();
      logic [18:0] rv;
      rv = ev(0,0,0,1,0,0,0,0,0,0,0,0,1,0,0,0);
      rst = 1'b0; mem_ready = 1'b1; opcode = OP_RTYPE; func = F_ADD; zero = 1'b0;
      #3;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset state: got %0d want 0", state); end
      tests++; if (outs !== rv) begin fails++; $display("FAIL reset outs: got %b want %b", outs, rv); end
      @(negedge clk); #1;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset hold state: got %0d want 0", state); end
      tests++; if (outs !== rv) begin fails++; $display("FAIL reset hold outs: got %b want %b", outs, rv); end
      rst = 1'b1; mem_ready = 1'b0;
   endtask

   task automatic test_rtype();
      logic [5:0]  fns[2] = '{F_ADD, F_SLT};
      logic [3:0]  sts[4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      logic [18:0] exps[4];
      for (int k = 0; k < 2; k++) begin
         opcode = OP_RTYPE; func = fns[k];
         exps = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0),
                  ev(0,0,0,0,0,0,0,0,0,0,0,1,0,2,0,0), ev(0,0,0,0,0,0,1,1,0,k,0,0,0,0,1,0)};
         for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            tests++; if (state !== sts[i]) begin fails++; $display("FAIL rtype%0d state c%0d: got %0d want %0d", k, i, state, sts[i]); end
            tests++; if (outs !== exps[i]) begin fails++; $display("FAIL rtype%0d outs c%0d: got %b want %b", k, i, outs, exps[i]); end
            @(negedge clk);
         end
         #1;
         tests++; if (state !== 4'd0) begin fails++; $display("FAIL rtype%0d end state: got %0d want 0", k, state); end
      end
   endtask

   task automatic test_lw_wait();
      logic [3:0]  sts[7] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6};
      logic        mrs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [18:0] exps[7];
      exps = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0),
               ev(0,0,0,0,0,0,0,0,0,0,0,1,2,0,0,0), ev(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0),
               ev(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0), ev(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0),
               ev(0,0,0,0,0,0,1,0,0,0,1,0,0,0,1,0)};
      opcode = OP_LW; func = 6'd0;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mrs[i]; #1;
         tests++; if (state !== sts[i]) begin fails++; $display("FAIL lw state c%0d: got %0d want %0d", i, state, sts[i]); end
         tests++; if (outs !== exps[i]) begin fails++; $display("FAIL lw outs c%0d: got %b want %b", i, outs, exps[i]); end
         @(negedge clk);
      end
      #1;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL lw end state: got %0d want 0", state); end
   endtask

   task automatic test_sw();
      logic [3:0]  sts[5] = '{4'd0, 4'd1, 4'd4, 4'd7, 4'd7};
      logic        mrs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [18:0] exps[5];
      exps = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0),
               ev(0,0,0,0,0,0,0,0,0,0,0,1,2,0,0,0), ev(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0),
               ev(0,0,1,0,1,0,0,0,0,0,0,0,0,0,1,0)};
      opcode = OP_SW; func = 6'd0;
      for (int i = 0; i < 5; i++) begin
         mem_ready = mrs[i]; #1;
         tests++; if (state !== sts[i]) begin fails++; $display("FAIL sw state c%0d: got %0d want %0d", i, state, sts[i]); end
         tests++; if (outs !== exps[i]) begin fails++; $display("FAIL sw outs c%0d: got %b want %b", i, outs, exps[i]); end
         @(negedge clk);
      end
      #1;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL sw end state: got %0d want 0", state); end
   endtask

   task automatic test_beq();
      logic [3:0]  sts[3] = '{4'd0, 4'd1, 4'd8};
      logic [18:0] exps[3];
      for (int z = 1; z >= 0; z--) begin
         opcode = OP_BEQ; func = 6'd0; zero = (z == 1);
         exps = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0),
                  ev(z,1,0,0,0,0,0,0,0,0,0,1,0,1,1,0)};
         for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; #1;
            tests++; if (state !== sts[i]) begin fails++; $display("FAIL beq z%0d state c%0d: got %0d want %0d", z, i, state, sts[i]); end
            tests++; if (outs !== exps[i]) begin fails++; $display("FAIL beq z%0d outs c%0d: got %b want %b", z, i, outs, exps[i]); end
            @(negedge clk);
         end
         #1;
         tests++; if (state !== 4'd0) begin fails++; $display("FAIL beq z%0d end state: got %0d want 0", z, state); end
      end
      zero = 1'b0;
   endtask

   task automatic test_jumps();
      logic [5:0]  ops[3] = '{OP_J, OP_JAL, OP_RTYPE};
      logic [5:0]  fns[3] = '{6'd0, 6'd0, F_JR};
      logic [3:0]  st3[3] = '{4'd9, 4'd10, 4'd11};
      logic [18:0] ex3[3];
      logic [18:0] exps[3];
      ex3 = '{ev(1,2,0,0,0,0,0,0,0,0,0,0,0,0,1,0), ev(1,2,0,0,0,0,1,0,1,0,0,0,0,0,1,0),
              ev(1,3,0,0,0,0,0,0,0,0,0,0,0,0,1,0)};
      for (int k = 0; k < 3; k++) begin
         opcode = ops[k]; func = fns[k];
         exps = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0), ex3[k]};
         for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b1; #1;
            tests++;
            if (state !== ((i == 2) ? st3[k] : 4'(i))) begin
               fails++; $display("FAIL jump%0d state c%0d: got %0d", k, i, state);
            end
            tests++; if (outs !== exps[i]) begin fails++; $display("FAIL jump%0d outs c%0d: got %b want %b", k, i, outs, exps[i]); end
            @(negedge clk);
         end
         #1;
         tests++; if (state !== 4'd0) begin fails++; $display("FAIL jump%0d end state: got %0d want 0", k, state); end
      end
   endtask

   task automatic test_itype();
      logic [5:0]  ops[2] = '{OP_ADDI, OP_SLTI};
      logic [3:0]  sts[4] = '{4'd0, 4'd1, 4'd12, 4'd13};
      logic [18:0] exps[4];
      for (int k = 0; k < 2; k++) begin
         opcode = ops[k]; func = 6'b101010;
         exps = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0),
                  ev(0,0,0,0,0,0,0,0,0,0,0,1,2,k,0,0), ev(0,0,0,0,0,0,1,0,0,k,0,0,0,0,1,0)};
         for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; #1;
            tests++; if (state !== sts[i]) begin fails++; $display("FAIL itype%0d state c%0d: got %0d want %0d", k, i, state, sts[i]); end
            tests++; if (outs !== exps[i]) begin fails++; $display("FAIL itype%0d outs c%0d: got %b want %b", k, i, outs, exps[i]); end
            @(negedge clk);
         end
         #1;
         tests++; if (state !== 4'd0) begin fails++; $display("FAIL itype%0d end state: got %0d want 0", k, state); end
      end
   endtask

   task automatic test_illegal();
      logic [5:0]  ops[2] = '{6'b111111, OP_RTYPE};
      logic [5:0]  fns[2] = '{F_ADD, 6'b000000};
      logic [3:0]  sts[3] = '{4'd0, 4'd0, 4'd1};
      logic        mrs[3] = '{1'b0, 1'b1, 1'b1};
      logic [18:0] exps[3];
      exps = '{ev(0,0,0,1,0,0,0,0,0,0,0,0,1,0,0,0), ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0),
               ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,1)};
      for (int k = 0; k < 2; k++) begin
         opcode = ops[k]; func = fns[k];
         for (int i = 0; i < 3; i++) begin
            mem_ready = mrs[i]; #1;
            tests++; if (state !== sts[i]) begin fails++; $display("FAIL illegal%0d state c%0d: got %0d want %0d", k, i, state, sts[i]); end
            tests++; if (outs !== exps[i]) begin fails++; $display("FAIL illegal%0d outs c%0d: got %b want %b", k, i, outs, exps[i]); end
            @(negedge clk);
         end
         #1;
         tests++; if (state !== 4'd0) begin fails++; $display("FAIL illegal%0d end state: got %0d want 0", k, state); end
      end
   endtask

   task automatic test_reset_mid_sw();
      logic [3:0]  sts[4] = '{4'd0, 4'd1, 4'd4, 4'd7};
      logic        mrs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [3:0]  jst[3] = '{4'd0, 4'd1, 4'd9};
      logic [18:0] jex[3];
      logic [18:0] rv;
      rv  = ev(0,0,0,1,0,0,0,0,0,0,0,0,1,0,0,0);
      jex = '{ev(1,0,0,1,0,1,0,0,0,0,0,0,1,0,0,0), ev(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0,0),
              ev(1,2,0,0,0,0,0,0,0,0,0,0,0,0,1,0)};
      opcode = OP_SW; func = 6'd0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = mrs[i]; #1;
         tests++; if (state !== sts[i]) begin fails++; $display("FAIL rstsw state c%0d: got %0d want %0d", i, state, sts[i]); end
         @(negedge clk);
      end
      #1;
      tests++; if (MemWrite !== 1'b1 || state !== 4'd7) begin fails++; $display("FAIL rstsw wait: got state %0d MemWrite %b want 7 1", state, MemWrite); end
      #1; rst = 1'b0; mem_ready = 1'b1; #1;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL rstsw async state: got %0d want 0", state); end
      tests++; if (outs !== rv) begin fails++; $display("FAIL rstsw async outs: got %b want %b", outs, rv); end
      @(negedge clk); #1;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL rstsw held state: got %0d want 0", state); end
      rst = 1'b1; opcode = OP_J;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b1; #1;
         tests++; if (state !== jst[i]) begin fails++; $display("FAIL rstsw refetch state c%0d: got %0d want %0d", i, state, jst[i]); end
         tests++; if (outs !== jex[i]) begin fails++; $display("FAIL rstsw refetch outs c%0d: got %b want %b", i, outs, jex[i]); end
         @(negedge clk);
      end
      #1;
      tests++; if (state !== 4'd0) begin fails++; $display("FAIL rstsw end state: got %0d want 0", state); end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw();
      test_beq();
      test_jumps();
      test_itype();
      test_illegal();
      test_reset_mid_sw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  Inst[31:26], taken from the instruction register and stable from DECODE until the instruction completes.
- func  in  6  Inst[5:0], with the same stability as opcode.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_en  out  1  PC load enable.
- PCsrc  out  2  PC source: 0 = ALU result, 1 = ALUOut (branch target), 2 = jump address, 3 = rs (jr).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite, IRWrite, RegWrite, RegDst, Jal, slt, MemToReg  out  1 each  same datapath meaning as in the single-cycle controller.
- ALUsrcA  out  1  0 = PC, 1 = register A.
- ALUsrcB  out  2  0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- ALUop  out  2  0 = add, 1 = sub, 2 = decode func, 3 = nop.
- state  out  4  current state, for debug.
- done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal  out  1  unsupported opcode or func detected in DECODE.
REQ-002 SHALL use only clk as its clock; rst SHALL be asynchronous and active-low.

Function
REQ-003 SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, R_EX=2, R_WB=3, MEM_ADDR=4, MEM_RD=5, LW_WB=6, MEM_WR=7, BEQ=8, JUMP=9, JAL=10, JR=11, I_EX=12, I_WB=13.
REQ-004 SHALL drive every output to 0 in every state unless a requirement below names it; encodings 14 and 15 SHALL go to FETCH on the next edge.
REQ-005 FETCH SHALL assert MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=1, ALUop=0, PCsrc=0.
- IRWrite=mem_ready and pc_en=mem_ready.
- Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-006 DECODE SHALL drive ALUsrcA=0, ALUsrcB=3, ALUop=0, and SHALL branch on the instruction:
- R-type add/sub/and/or/slt -> R_EX; R-type jr (func 001000) -> JR.
- lw/sw -> MEM_ADDR; beq -> BEQ; j -> JUMP; jal -> JAL; addi/slti -> I_EX.
- Any other opcode, or an unlisted R-type func, SHALL assert illegal=1 for that cycle and return to FETCH with no architectural side effect.
REQ-007 R_EX SHALL drive ALUsrcA=1, ALUsrcB=0, ALUop=2, then go to R_WB.
REQ-008 R_WB SHALL drive RegDst=1, RegWrite=1, done=1, slt=1 only when func=slt, then go to FETCH.
REQ-009 MEM_ADDR SHALL drive ALUsrcA=1, ALUsrcB=2, ALUop=0, then go to MEM_RD for lw or MEM_WR for sw.
REQ-010 MEM_RD SHALL drive MemRead=1, IorD=1, and SHALL wait while mem_ready=0 before going to LW_WB.
REQ-011 LW_WB SHALL drive MemToReg=1, RegWrite=1, RegDst=0, done=1, then go to FETCH.
REQ-012 MEM_WR SHALL drive MemWrite=1, IorD=1, and SHALL wait while mem_ready=0; done=mem_ready; go to FETCH when mem_ready=1.
REQ-013 BEQ SHALL drive ALUsrcA=1, ALUsrcB=0, ALUop=1, PCsrc=1, pc_en=zero, done=1, then go to FETCH.
REQ-014 JUMP SHALL drive PCsrc=2, pc_en=1, done=1, then go to FETCH.
REQ-015 JAL SHALL drive PCsrc=2, pc_en=1, Jal=1, RegWrite=1, done=1, then go to FETCH.
REQ-016 JR SHALL drive PCsrc=3, pc_en=1, done=1, then go to FETCH.
REQ-017 I_EX SHALL drive ALUsrcA=1, ALUsrcB=2, ALUop=0 for addi or 1 for slti, then go to I_WB.
REQ-018 I_WB SHALL drive RegDst=0, RegWrite=1, done=1, slt=1 for slti, then go to FETCH.
REQ-019 When mem_ready=0 in a wait state, the state and all write enables SHALL hold; no register write or PC update SHALL occur while waiting.
REQ-020 Latency with mem_ready always 1 SHALL be: R-type 4 cycles; lw 5; sw 4; addi/slti 4; beq/j/jal/jr 3.

Reset
REQ-021 rst=0 SHALL force state=FETCH immediately, independent of clk, from any state including mid-wait.
REQ-022 While rst=0, outputs SHALL equal the FETCH values with mem_ready masked to 0: MemRead=1, ALUsrcB=1, all other outputs 0 (pc_en, IRWrite, done and illegal all 0).
REQ-023 On the first rising edge after rst returns to 1, the controller SHALL begin a normal fetch.

Verification
REQ-024 add (opcode 0, func 100000), mem_ready=1 -> states 0,1,2,3; RegWrite=1, RegDst=1 and done=1 only in state 3.
REQ-025 lw, with mem_ready=0 for 2 cycles in MEM_RD -> MEM_RD held 3 cycles, RegWrite=0 throughout the wait, lw total 7 cycles.
REQ-026 beq with zero=1 -> pc_en=1 and PCsrc=1 in BEQ; with zero=0 -> pc_en=0 in BEQ; both take 3 cycles.
REQ-027 opcode 6'b111111 -> illegal=1 in DECODE, next state FETCH, no RegWrite/MemWrite/pc_en asserted outside FETCH.
REQ-028 rst=0 asserted mid-MEM_WR (between edges) -> state=0 and MemWrite=0 immediately; after release, a normal fetch proceeds.
REQ-029 jal -> Jal=1, RegWrite=1, PCsrc=2, pc_en=1 in state 10, total 3 cycles.
